// File: rtl/pe_mac_sat_if.sv
// rtl/pe_mac_sat_if.sv - operand, control and readout bundle for one MAC PE
interface pe_mac_sat_if #(
  parameter int IN_LEN  = 8,
  parameter int OUT_LEN = 16
);
  // control and operands into the PE
  logic               cal_en;
  logic               cal_done;
  logic               acc_mode;
  logic [OUT_LEN-1:0] bias;
  logic [IN_LEN-1:0]  westin;
  logic [IN_LEN-1:0]  northin;
  // upstream readout chain into the PE
  logic               din_val;
  logic [OUT_LEN-1:0] din;
  // forwarding to neighbour PEs
  logic               n_cal_en;
  logic               n_cal_done;
  logic [IN_LEN-1:0]  eastout;
  logic [IN_LEN-1:0]  southout;
  // readout chain and status out of the PE
  logic               dout_val;
  logic [OUT_LEN-1:0] dout;
  logic               sat_flag;
  logic               fifo_ovf;

  // environment / upstream side
  modport master (
    output cal_en, cal_done, acc_mode, bias, westin, northin, din_val, din,
    input  n_cal_en, n_cal_done, eastout, southout, dout_val, dout, sat_flag, fifo_ovf
  );

  // the PE itself
  modport slave (
    input  cal_en, cal_done, acc_mode, bias, westin, northin, din_val, din,
    output n_cal_en, n_cal_done, eastout, southout, dout_val, dout, sat_flag, fifo_ovf
  );
endinterface

// File: rtl/pe_mac_sat.sv
// rtl/pe_mac_sat.sv - signed saturating MAC PE with buffered readout daisy chain
module pe_mac_sat #(
  parameter int IN_LEN  = 8,
  parameter int OUT_LEN = 16,
  parameter int ACC_LEN = 32,
  parameter int FRAC    = 0,
  parameter int N       = 3
) (
  input logic         clk,
  input logic         sys_rst,
  pe_mac_sat_if.slave pe
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);

  // clamp bounds of the OUT_LEN result, expressed at accumulator width
  localparam logic signed [ACC_LEN-1:0] RES_MAX =
    {{(ACC_LEN-OUT_LEN+1){1'b0}}, {(OUT_LEN-1){1'b1}}};
  localparam logic signed [ACC_LEN-1:0] RES_MIN =
    {{(ACC_LEN-OUT_LEN+1){1'b1}}, {(OUT_LEN-1){1'b0}}};

  // registered state
  logic signed [ACC_LEN-1:0] acc_q;
  logic                      n_cal_en_q;
  logic                      n_cal_done_q;
  logic [IN_LEN-1:0]         eastout_q;
  logic [IN_LEN-1:0]         southout_q;
  logic                      dout_val_q;
  logic [OUT_LEN-1:0]        dout_q;
  logic                      sat_flag_q;
  logic                      fifo_ovf_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [OUT_LEN-1:0]        fifo_q [N];

  // datapath
  logic signed [2*IN_LEN-1:0] prod;
  logic signed [ACC_LEN-1:0]  base;
  logic signed [ACC_LEN-1:0]  acc_d;
  logic signed [ACC_LEN-1:0]  acc_shr;
  logic                       start;
  logic                       clamp_hi;
  logic                       clamp_lo;
  logic [OUT_LEN-1:0]         res;

  // readout control
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic bypass;
  logic push;
  logic drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign prod  = $signed(pe.westin) * $signed(pe.northin);
  // rising edge of cal_en as seen against our own forwarded copy
  assign start = pe.cal_en & ~n_cal_en_q;
  // bias is aligned to the accumulator's fixed-point position
  assign base  = pe.acc_mode ? (ACC_LEN'($signed(pe.bias)) <<< FRAC) : '0;

  // next accumulator value; also the value a same-cycle capture sees
  always_comb begin
    acc_d = acc_q;
    if (pe.cal_en) begin
      acc_d = (start ? base : acc_q) + ACC_LEN'(prod);
    end
  end

  assign acc_shr  = acc_d >>> FRAC;
  assign clamp_hi = acc_shr > RES_MAX;
  assign clamp_lo = acc_shr < RES_MIN;
  assign res      = clamp_hi ? RES_MAX[OUT_LEN-1:0] :
                    clamp_lo ? RES_MIN[OUT_LEN-1:0] :
                               acc_shr[OUT_LEN-1:0];

  // The own result goes straight into the readout register on its capture
  // edge, so it never waits; it only displaces the FIFO head and din.
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(N));
  assign pop        = ~pe.cal_done & ~fifo_empty;
  assign bypass     = ~pe.cal_done & fifo_empty & pe.din_val;
  assign push       = pe.din_val & ~bypass & (~fifo_full | pop);
  assign drop       = pe.din_val & ~bypass & fifo_full & ~pop;

  // forwarding, accumulation, readout mux register, FIFO pointers and sticky flags
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      acc_q        <= '0;
      n_cal_en_q   <= 1'b0;
      n_cal_done_q <= 1'b0;
      eastout_q    <= '0;
      southout_q   <= '0;
      dout_val_q   <= 1'b0;
      dout_q       <= '0;
      sat_flag_q   <= 1'b0;
      fifo_ovf_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      n_cal_en_q   <= pe.cal_en;
      n_cal_done_q <= pe.cal_done;
      eastout_q    <= pe.westin;
      southout_q   <= pe.northin;
      acc_q        <= acc_d;

      if (pe.cal_done) begin
        dout_q     <= res;
        dout_val_q <= 1'b1;
        if (clamp_hi | clamp_lo) begin
          sat_flag_q <= 1'b1;
        end
      end else if (pop) begin
        dout_q     <= fifo_q[rd_ptr_q];
        dout_val_q <= 1'b1;
      end else if (bypass) begin
        dout_q     <= pe.din;
        dout_val_q <= 1'b1;
      end else begin
        dout_val_q <= 1'b0;
      end

      if (drop) begin
        fifo_ovf_q <= 1'b1;
      end
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are meaningless while the count says empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= pe.din;
    end
  end

  assign pe.n_cal_en   = n_cal_en_q;
  assign pe.n_cal_done = n_cal_done_q;
  assign pe.eastout    = eastout_q;
  assign pe.southout   = southout_q;
  assign pe.dout_val   = dout_val_q;
  assign pe.dout       = dout_q;
  assign pe.sat_flag   = sat_flag_q;
  assign pe.fifo_ovf   = fifo_ovf_q;

endmodule

// File: tb/tb_pe_mac_sat.sv
// tb/tb_pe_mac_sat.sv - directed self-checking bench for pe_mac_sat
module tb_pe_mac_sat;
  logic clk = 1'b0;
  logic sys_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // if0/u0: default PE; if1/u1: OUT_LEN=8, N=2; if2/u2: FRAC=4
  pe_mac_sat_if #(.IN_LEN(8), .OUT_LEN(16)) if0 ();
  pe_mac_sat_if #(.IN_LEN(8), .OUT_LEN(8))  if1 ();
  pe_mac_sat_if #(.IN_LEN(8), .OUT_LEN(16)) if2 ();

  pe_mac_sat #(.IN_LEN(8), .OUT_LEN(16), .ACC_LEN(32), .FRAC(0), .N(3)) u0 (
    .clk(clk), .sys_rst(sys_rst), .pe(if0.slave));
  pe_mac_sat #(.IN_LEN(8), .OUT_LEN(8), .ACC_LEN(32), .FRAC(0), .N(2)) u1 (
    .clk(clk), .sys_rst(sys_rst), .pe(if1.slave));
  pe_mac_sat #(.IN_LEN(8), .OUT_LEN(16), .ACC_LEN(32), .FRAC(4), .N(3)) u2 (
    .clk(clk), .sys_rst(sys_rst), .pe(if2.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if0.cal_en = 0; if0.cal_done = 0; if0.acc_mode = 0; if0.bias = '0;
    if0.westin = '0; if0.northin = '0; if0.din_val = 0; if0.din = '0;
    if1.cal_en = 0; if1.cal_done = 0; if1.acc_mode = 0; if1.bias = '0;
    if1.westin = '0; if1.northin = '0; if1.din_val = 0; if1.din = '0;
    if2.cal_en = 0; if2.cal_done = 0; if2.acc_mode = 0; if2.bias = '0;
    if2.westin = '0; if2.northin = '0; if2.din_val = 0; if2.din = '0;
  endtask

  task automatic do_reset();
    idle();
    sys_rst = 1;
    step();
    sys_rst = 0;
  endtask

  task automatic test_reset();
    idle();
    sys_rst = 1;
    if0.cal_en = 1; if0.cal_done = 1; if0.westin = 8'd5; if0.northin = 8'd6;
    if0.din_val = 1; if0.din = 16'd9;
    step();
    step();
    n_tests++; if ({if0.n_cal_en, if0.n_cal_done, if0.eastout, if0.southout} !== 18'd0) begin n_fail++; $display("FAIL reset_fwd act=%0h exp=0", {if0.n_cal_en, if0.n_cal_done, if0.eastout, if0.southout}); end
    n_tests++; if ({if0.dout_val, if0.dout, if0.sat_flag, if0.fifo_ovf} !== 19'd0) begin n_fail++; $display("FAIL reset_rd act=%0h exp=0", {if0.dout_val, if0.dout, if0.sat_flag, if0.fifo_ovf}); end
    n_tests++; if ({if1.dout_val, if1.dout, if1.fifo_ovf, if2.dout_val, if2.dout} !== 27'd0) begin n_fail++; $display("FAIL reset_others act=%0h exp=0", {if1.dout_val, if1.dout, if1.fifo_ovf, if2.dout_val, if2.dout}); end
    sys_rst = 0;
    idle();
    step();
  endtask

  task automatic test_basic_mac();
    do_reset();
    if0.cal_en = 1; if0.westin = 8'd2; if0.northin = 8'd2;
    step();
    n_tests++; if (if0.eastout !== 8'd2 || if0.southout !== 8'd2) begin n_fail++; $display("FAIL fwd_c5 act=%0d/%0d exp=2/2", if0.eastout, if0.southout); end
    n_tests++; if (if0.n_cal_en !== 1'b1 || if0.dout_val !== 1'b0) begin n_fail++; $display("FAIL ncalen_c5 act=%b/%b exp=1/0", if0.n_cal_en, if0.dout_val); end
    if0.westin = 8'd3; if0.northin = 8'd3;
    step();
    n_tests++; if (if0.eastout !== 8'd3 || if0.southout !== 8'd3 || if0.n_cal_en !== 1'b1) begin n_fail++; $display("FAIL fwd_c6 act=%0d/%0d/%b exp=3/3/1", if0.eastout, if0.southout, if0.n_cal_en); end
    if0.westin = 8'd4; if0.northin = 8'd4;
    step();
    n_tests++; if (if0.eastout !== 8'd4 || if0.southout !== 8'd4 || if0.n_cal_en !== 1'b1) begin n_fail++; $display("FAIL fwd_c7 act=%0d/%0d/%b exp=4/4/1", if0.eastout, if0.southout, if0.n_cal_en); end
    if0.cal_en = 0; if0.cal_done = 1; if0.westin = '0; if0.northin = '0;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'd29) begin n_fail++; $display("FAIL basic_dout act=%b/%0d exp=1/29", if0.dout_val, if0.dout); end
    n_tests++; if (if0.n_cal_en !== 1'b0 || if0.n_cal_done !== 1'b1) begin n_fail++; $display("FAIL basic_ndone act=%b/%b exp=0/1", if0.n_cal_en, if0.n_cal_done); end
    if0.cal_done = 0;
    step();
    n_tests++; if (if0.dout_val !== 1'b0 || if0.dout !== 16'd29 || if0.n_cal_done !== 1'b0) begin n_fail++; $display("FAIL basic_hold act=%b/%0d/%b exp=0/29/0", if0.dout_val, if0.dout, if0.n_cal_done); end
  endtask

  task automatic test_preload();
    idle();
    step();
    if0.acc_mode = 1; if0.bias = 16'hFFFB; if0.cal_en = 1; if0.cal_done = 1;
    if0.westin = 8'hFD; if0.northin = 8'd7;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'hFFE6) begin n_fail++; $display("FAIL preload_dout act=%b/%0h exp=1/ffe6", if0.dout_val, if0.dout); end
    n_tests++; if (if0.sat_flag !== 1'b0) begin n_fail++; $display("FAIL preload_sat act=%b exp=0", if0.sat_flag); end
    idle();
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    if1.cal_en = 1; if1.westin = 8'd127; if1.northin = 8'd127;
    step();
    if1.cal_done = 1;
    step();
    n_tests++; if (if1.dout_val !== 1'b1 || if1.dout !== 8'd127) begin n_fail++; $display("FAIL sat_pos act=%b/%0h exp=1/7f", if1.dout_val, if1.dout); end
    n_tests++; if (if1.sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag act=%b exp=1", if1.sat_flag); end
    idle();
    step();
    n_tests++; if (if1.sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_sticky act=%b exp=1", if1.sat_flag); end
    do_reset();
    n_tests++; if (if1.sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clear act=%b exp=0", if1.sat_flag); end
    if1.cal_en = 1; if1.cal_done = 1; if1.westin = 8'h80; if1.northin = 8'd127;
    step();
    n_tests++; if (if1.dout !== 8'h80 || if1.sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_neg act=%0h/%b exp=80/1", if1.dout, if1.sat_flag); end
    idle();
    step();
  endtask

  task automatic test_frac();
    do_reset();
    if2.cal_en = 1; if2.cal_done = 1; if2.westin = 8'd29; if2.northin = 8'd1;
    step();
    n_tests++; if (if2.dout !== 16'd1 || if2.dout_val !== 1'b1) begin n_fail++; $display("FAIL frac_pos act=%0h/%b exp=1/1", if2.dout, if2.dout_val); end
    idle();
    step();
    if2.cal_en = 1; if2.cal_done = 1; if2.westin = 8'hE3; if2.northin = 8'd1;
    step();
    n_tests++; if (if2.dout !== 16'hFFFE) begin n_fail++; $display("FAIL frac_neg act=%0h exp=fffe", if2.dout); end
    idle();
    step();
    if2.acc_mode = 1; if2.bias = 16'd3; if2.cal_en = 1; if2.cal_done = 1;
    if2.westin = 8'd1; if2.northin = 8'd5;
    step();
    n_tests++; if (if2.dout !== 16'd3) begin n_fail++; $display("FAIL frac_bias act=%0h exp=3", if2.dout); end
    idle();
    step();
  endtask

  task automatic test_collision();
    do_reset();
    if0.cal_en = 1; if0.westin = 8'd2; if0.northin = 8'd2; step();
    if0.westin = 8'd3; if0.northin = 8'd3; step();
    if0.westin = 8'd4; if0.northin = 8'd4; step();
    if0.cal_en = 0; if0.westin = '0; if0.northin = '0;
    if0.cal_done = 1; if0.din_val = 1; if0.din = 16'd10;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'd29) begin n_fail++; $display("FAIL coll_c8 act=%b/%0d exp=1/29", if0.dout_val, if0.dout); end
    if0.cal_done = 0; if0.din = 16'd11;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'd10) begin n_fail++; $display("FAIL coll_c9 act=%b/%0d exp=1/10", if0.dout_val, if0.dout); end
    if0.din = 16'd12;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'd11) begin n_fail++; $display("FAIL coll_c10 act=%b/%0d exp=1/11", if0.dout_val, if0.dout); end
    if0.din_val = 0; if0.din = '0;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'd12) begin n_fail++; $display("FAIL coll_c11 act=%b/%0d exp=1/12", if0.dout_val, if0.dout); end
    step();
    n_tests++; if (if0.dout_val !== 1'b0) begin n_fail++; $display("FAIL coll_drain act=%b exp=0", if0.dout_val); end
    if0.din_val = 1; if0.din = 16'd55;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'd55) begin n_fail++; $display("FAIL bypass act=%b/%0d exp=1/55", if0.dout_val, if0.dout); end
    if0.din_val = 0;
    step();
    n_tests++; if (if0.dout_val !== 1'b0 || if0.fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL bypass_end act=%b/%b exp=0/0", if0.dout_val, if0.fifo_ovf); end
  endtask

  task automatic test_back_to_back_ovf();
    do_reset();
    if1.cal_en = 1; if1.cal_done = 1; if1.westin = 8'd1; if1.northin = 8'd5;
    if1.din_val = 1; if1.din = 8'd1;
    step();
    n_tests++; if (if1.dout_val !== 1'b1 || if1.dout !== 8'd5) begin n_fail++; $display("FAIL b2b_r0 act=%b/%0d exp=1/5", if1.dout_val, if1.dout); end
    if1.northin = 8'd6; if1.din = 8'd2;
    step();
    n_tests++; if (if1.dout !== 8'd11 || if1.fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_r1 act=%0d/%b exp=11/0", if1.dout, if1.fifo_ovf); end
    if1.northin = 8'd7; if1.din = 8'd3;
    step();
    n_tests++; if (if1.dout !== 8'd18 || if1.fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_r2 act=%0d/%b exp=18/1", if1.dout, if1.fifo_ovf); end
    if1.cal_en = 0; if1.cal_done = 0; if1.westin = '0; if1.northin = '0; if1.din = 8'd4;
    step();
    n_tests++; if (if1.dout_val !== 1'b1 || if1.dout !== 8'd1) begin n_fail++; $display("FAIL ovf_q0 act=%b/%0d exp=1/1", if1.dout_val, if1.dout); end
    if1.din_val = 0; if1.din = '0;
    step();
    n_tests++; if (if1.dout_val !== 1'b1 || if1.dout !== 8'd2) begin n_fail++; $display("FAIL ovf_q1 act=%b/%0d exp=1/2", if1.dout_val, if1.dout); end
    step();
    n_tests++; if (if1.dout_val !== 1'b1 || if1.dout !== 8'd4) begin n_fail++; $display("FAIL ovf_q2 act=%b/%0d exp=1/4", if1.dout_val, if1.dout); end
    step();
    n_tests++; if (if1.dout_val !== 1'b0 || if1.fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_end act=%b/%b exp=0/1", if1.dout_val, if1.fifo_ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if0.cal_en = 1; if0.westin = 8'd5; if0.northin = 8'd5;
    step();
    if0.cal_done = 1; if0.din_val = 1; if0.din = 16'd77;
    step();
    n_tests++; if (if0.dout !== 16'd50) begin n_fail++; $display("FAIL rmid_pre act=%0d exp=50", if0.dout); end
    sys_rst = 1; if0.cal_done = 0; if0.din_val = 0; if0.westin = 8'd9; if0.northin = 8'd9;
    step();
    n_tests++; if ({if0.n_cal_en, if0.n_cal_done, if0.eastout, if0.southout, if0.dout_val, if0.dout, if0.sat_flag, if0.fifo_ovf} !== 37'd0) begin n_fail++; $display("FAIL rmid_zero act=%0h exp=0", {if0.n_cal_en, if0.n_cal_done, if0.eastout, if0.southout, if0.dout_val, if0.dout, if0.sat_flag, if0.fifo_ovf}); end
    sys_rst = 0; if0.cal_en = 0; if0.westin = '0; if0.northin = '0; if0.cal_done = 1;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'd0) begin n_fail++; $display("FAIL rmid_acc act=%b/%0d exp=1/0", if0.dout_val, if0.dout); end
    if0.cal_done = 0;
    step();
    n_tests++; if (if0.dout_val !== 1'b0) begin n_fail++; $display("FAIL rmid_flush act=%b/%0d exp=0", if0.dout_val, if0.dout); end
    if0.cal_en = 1; if0.westin = 8'd2; if0.northin = 8'd2;
    step();
    if0.cal_en = 0; if0.cal_done = 1; if0.westin = '0; if0.northin = '0;
    step();
    n_tests++; if (if0.dout_val !== 1'b1 || if0.dout !== 16'd4) begin n_fail++; $display("FAIL rmid_rerun act=%b/%0d exp=1/4", if0.dout_val, if0.dout); end
    idle();
    step();
  endtask

  initial begin
    sys_rst = 1;
    idle();
    test_reset();
    test_basic_mac();
    test_preload();
    test_saturation();
    test_frac();
    test_collision();
    test_back_to_back_ovf();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_mac_sat.md
# pe_mac_sat

Signed multiply-accumulate processing element for the systolic matrix array. It succeeds the fixed-width MAC PE and adds:
- parametrised accumulator width with a fixed-point output shift;
- an optional bias preload;
- saturating output with a sticky flag;
- a buffered readout daisy chain, so a PE's own result and upstream results never collide.

Operands flow east and south. Results drain through the `din`/`dout` chain.

## Interface
Parameters:
- `IN_LEN`, 8: operand width, signed two's complement.
- `OUT_LEN`, 16: result, bias and readout width, signed.
- `ACC_LEN`, 32: accumulator width. Must be ≥ 2*`IN_LEN`.
- `FRAC`, 0: arithmetic right shift applied to the accumulator before saturation. Range 0..`ACC_LEN`-`OUT_LEN`.
- `N`, 3: readout FIFO depth, which is the maximum number of upstream results buffered.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `sys_rst`, in, 1: reset, synchronous, active-high.
- `cal_en`, in, 1: accumulate this cycle.
- `cal_done`, in, 1: capture the result this cycle.
- `acc_mode`, in, 1: 0 = clear on start; 1 = preload `bias` on start.
- `bias`, in, `OUT_LEN`: preload value, sampled on the start cycle.
- `westin`, in, `IN_LEN`: row operand.
- `northin`, in, `IN_LEN`: column operand.
- `din_val`, in, 1: upstream result valid.
- `din`, in, `OUT_LEN`: upstream result.
- `n_cal_en`, out, 1: `cal_en` delayed 1 cycle, to the neighbour PE.
- `n_cal_done`, out, 1: `cal_done` delayed 1 cycle.
- `eastout`, out, `IN_LEN`: `westin` delayed 1 cycle.
- `southout`, out, `IN_LEN`: `northin` delayed 1 cycle.
- `dout_val`, out, 1: readout valid.
- `dout`, out, `OUT_LEN`: readout data.
- `sat_flag`, out, 1: sticky; some captured result was clamped.
- `fifo_ovf`, out, 1: sticky; an upstream result was dropped.

## Operation
- **Product:** `p` = `westin` × `northin`, signed, 2*`IN_LEN` bits, sign-extended to `ACC_LEN`.
- **Start cycle:** a cycle with `cal_en`=1 and `n_cal_en`=0, i.e. the rising edge of `cal_en`.
  - `acc` ← `base` + `p`.
  - `base` = 0 when `acc_mode`=0.
  - `base` = sign-extended `bias` << `FRAC` when `acc_mode`=1.
- **Continue:** `cal_en`=1 and `n_cal_en`=1 → `acc` ← `acc` + `p`.
- **Hold:** `cal_en`=0 → `acc` holds.
- **Wrap:** `acc` wraps modulo 2^`ACC_LEN`; there is no internal overflow detection.
- **Capture (`cal_done`=1):** `v` = `acc_next` >>> `FRAC` (arithmetic shift, truncation toward −∞).
  - `acc_next` includes this cycle's product if `cal_en`=1 in the same cycle.
  - `res` = `v` clamped to [−2^(`OUT_LEN`−1), 2^(`OUT_LEN`−1)−1].
  - If clamped, `sat_flag` ← 1.
  - `res` is marked pending.
- **Readout mux, evaluated every cycle in priority order:**
  1. Pending own result → `dout`=`res`, `dout_val`=1.
  2. Else, FIFO non-empty → pop the head to `dout`.
  3. Else, `din_val` → `dout`=`din` (bypass).
  4. Else, `dout_val`=0 and `dout` holds its last value.
- **FIFO push:** `din_val`=1 pushes `din` into the FIFO whenever `din` is not taken by the bypass.
  - FIFO full and no pop this cycle → `din` is dropped and `fifo_ovf` ← 1.
  - A push and a pop in the same cycle are both allowed.
- **Ordering:** the own result always precedes any upstream result arriving in the same cycle or later. Upstream order is preserved.
- **Back-to-back capture:** `cal_done` on consecutive cycles emits one result per cycle. The FIFO absorbs the displaced `din` stream.
- **New start while pending:** a start cycle while a result is still pending is legal; the pending `res` is already latched.

## Timing
- **Reset:** `sys_rst`=1 at an edge clears the following:
  - `acc`;
  - the FIFO (made empty);
  - the pending marker;
  - all outputs: `n_cal_en`, `n_cal_done`, `eastout`, `southout`, `dout_val`, `dout`, `sat_flag`, `fifo_ovf`.
- **Reset mid-operation:** discards the partial accumulation and any buffered results. The first `cal_en` after reset is a start cycle.
- **Forwarding:** `eastout`, `southout`, `n_cal_en` and `n_cal_done` are registered with 1-cycle latency.
- **Own result:** `cal_done` at edge k → `dout_val`=1 with `res` after edge k+1.
- **Bypass:** `din_val` at edge k with an empty FIFO and nothing pending → `dout` at edge k+1.
- **Displaced data:** each displaced `din` item adds 1 cycle per queued entry ahead of it.
- **Throughput:** at most one readout word per cycle.

## Test plan
- **Basic MAC and forwarding.**
  - Stimulus: `acc_mode`=0, `FRAC`=0. `cal_en` cycles 4–6 with `westin`=`northin`=2, 3, 4. `cal_done` cycle 7.
  - Response: `dout_val`=1, `dout`=29 at cycle 8. `eastout`/`southout` = 2, 3, 4 at cycles 5–7. `n_cal_en` high cycles 5–7.
- **Preload, signed, same-cycle capture.**
  - Stimulus: `acc_mode`=1, `bias`=−5. Single cycle with `cal_en`=`cal_done`=1, `westin`=−3, `northin`=7.
  - Response: `dout`=−26 next cycle; `sat_flag`=0.
- **Saturation** (`OUT_LEN`=8).
  - Stimulus: two cycles of 127×127.
  - Response: `dout`=127 and `sat_flag`=1.
  - After reset: −128×127 → `dout`=−128.
- **FRAC=4 rounding.**
  - 29 → `dout`=1.
  - −29 → `dout`=−2.
- **Readout collision.**
  - Stimulus: `cal_done` at cycle 7 (result 29). `din_val` cycles 7–9 with `din`=10, 11, 12.
  - Response: `dout`=29, 10, 11, 12 at cycles 8–11, `dout_val` continuous.
  - A subsequent isolated `din` with an empty FIFO bypasses with 1-cycle latency.
- **Overflow and reset.**
  - `N`=2: three `cal_done` pulses back-to-back plus a continuous `din` stream → `fifo_ovf`=1 and exactly one word dropped, oldest-first order kept.
  - `sys_rst` mid-accumulation → all outputs 0 next cycle, and the next run starts from 0.
